// File: rtl/branch_resolve_unit_pkg.sv
// Shared DLX control-transfer definitions for the branch resolve unit:
// opcode constants, CTI classification and the BTB entry layout.
package branch_resolve_unit_pkg;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQZ = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;
    localparam logic [5:0] OP_JR   = 6'h12;
    localparam logic [5:0] OP_JALR = 6'h13;

    // Entry fields are sized for the widest supported configuration (XLEN <= 64).
    localparam int BRU_XLEN_MAX = 64;
    localparam int BRU_CTR_MAX  = 4;

    typedef enum logic [2:0] {
        CTI_NONE,
        CTI_J,
        CTI_JAL,
        CTI_BEQZ,
        CTI_BNEZ,
        CTI_JR,
        CTI_JALR
    } cti_kind_e;

    typedef struct packed {
        logic                    valid;
        logic [BRU_XLEN_MAX-1:0] tag;
        logic [BRU_XLEN_MAX-1:0] target;
        logic [BRU_CTR_MAX-1:0]  ctr;
    } btb_entry_t;

    function automatic cti_kind_e decode_cti(input logic [5:0] op);
        case (op)
            OP_J:    return CTI_J;
            OP_JAL:  return CTI_JAL;
            OP_BEQZ: return CTI_BEQZ;
            OP_BNEZ: return CTI_BNEZ;
            OP_JR:   return CTI_JR;
            OP_JALR: return CTI_JALR;
            default: return CTI_NONE;
        endcase
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-prediction and resolve/redirect signal bundle of the branch resolve unit.
// master = pipeline side, slave = branch resolve unit.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
) ();
    logic [XLEN-1:0] f_pc;
    logic            f_pred_taken;
    logic [XLEN-1:0] f_pred_target;
    logic            r_valid;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1;
    logic            r_pred_taken;
    logic [XLEN-1:0] r_pred_target;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            link_we;
    logic [XLEN-1:0] link_data;

    modport master (
        output f_pc, r_valid, r_instr, r_pc, r_rs1, r_pred_taken, r_pred_target,
        input  f_pred_taken, f_pred_target, redirect, redirect_pc, link_we, link_data
    );

    modport slave (
        input  f_pc, r_valid, r_instr, r_pc, r_rs1, r_pred_taken, r_pred_target,
        output f_pred_taken, f_pred_target, redirect, redirect_pc, link_we, link_data
    );
endinterface

// File: rtl/branch_resolve_unit_btb.sv
// bru_btb: direct-mapped branch target buffer with saturating taken counters.
// Lookups read the registered table; an update becomes visible the next cycle.
module bru_btb
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 16,
    parameter int CTR_BITS  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:2] i_f_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_upd_en,
    input  logic [XLEN-1:2] i_upd_pc,
    input  logic            i_upd_cti,
    input  logic            i_upd_taken,
    input  logic [XLEN-1:0] i_upd_target
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam logic [CTR_BITS-1:0] CTR_SAT  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    btb_entry_t r_tab [BTB_DEPTH];

    logic [IDX_W-1:0]         w_f_idx, w_u_idx;
    logic [XLEN-IDX_W-3:0]    w_f_tag, w_u_tag;
    logic                     w_f_hit, w_u_hit;
    logic [CTR_BITS-1:0]      w_f_ctr, w_u_ctr, w_ctr_nxt;

    assign w_f_idx = i_f_pc[IDX_W+1:2];
    assign w_f_tag = i_f_pc[XLEN-1:IDX_W+2];
    assign w_u_idx = i_upd_pc[IDX_W+1:2];
    assign w_u_tag = i_upd_pc[XLEN-1:IDX_W+2];

    assign w_f_hit = r_tab[w_f_idx].valid && (r_tab[w_f_idx].tag == BRU_XLEN_MAX'(w_f_tag));
    assign w_u_hit = r_tab[w_u_idx].valid && (r_tab[w_u_idx].tag == BRU_XLEN_MAX'(w_u_tag));
    assign w_f_ctr = r_tab[w_f_idx].ctr[CTR_BITS-1:0];
    assign w_u_ctr = r_tab[w_u_idx].ctr[CTR_BITS-1:0];

    assign o_pred_taken  = w_f_hit && w_f_ctr[CTR_BITS-1];
    assign o_pred_target = o_pred_taken ? r_tab[w_f_idx].target[XLEN-1:0] : '0;

    always_comb begin
        w_ctr_nxt = w_u_ctr;
        if (i_upd_taken && (w_u_ctr != CTR_SAT)) begin
            w_ctr_nxt = w_u_ctr + 1'b1;
        end else if (!i_upd_taken && (w_u_ctr != '0)) begin
            w_ctr_nxt = w_u_ctr - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_tab[i].valid <= 1'b0;
            end
        end else if (i_upd_en) begin
            if (i_upd_cti) begin
                if (w_u_hit) begin
                    r_tab[w_u_idx].ctr <= BRU_CTR_MAX'(w_ctr_nxt);
                    if (i_upd_taken) begin
                        r_tab[w_u_idx].target <= BRU_XLEN_MAX'(i_upd_target);
                    end
                end else if (i_upd_taken) begin
                    r_tab[w_u_idx] <= '{valid:  1'b1,
                                        tag:    BRU_XLEN_MAX'(w_u_tag),
                                        target: BRU_XLEN_MAX'(i_upd_target),
                                        ctr:    BRU_CTR_MAX'(CTR_WEAK)};
                end
            end else if (w_u_hit) begin
                // A non-CTI at this PC means the entry is stale (e.g. code was rewritten).
                r_tab[w_u_idx].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// DLX branch resolve unit: decodes CTIs, computes target/direction, issues registered
// redirects and r31 link writes. Optional BTB predictor enabled by macro BRU_BTB_EN.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 16,
    parameter int CTR_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_unit_if.slave bus
);
    cti_kind_e       w_kind;
    logic [XLEN-1:0] w_pc4, w_imm26, w_imm16, w_tgt_raw, w_tgt;
    logic            w_taken, w_is_cti, w_link, w_mispred;
    logic            w_unused_fpc;

    logic            r_redirect, r_link_we;
    logic [XLEN-1:0] r_redirect_pc, r_link_data;

    assign w_kind  = decode_cti(bus.r_instr[31:26]);
    assign w_pc4   = bus.r_pc + XLEN'(4);
    assign w_imm26 = {{(XLEN-26){bus.r_instr[25]}}, bus.r_instr[25:0]};
    assign w_imm16 = {{(XLEN-16){bus.r_instr[15]}}, bus.r_instr[15:0]};

    always_comb begin
        w_tgt_raw = '0;
        w_taken   = 1'b0;
        w_is_cti  = 1'b1;
        w_link    = 1'b0;
        case (w_kind)
            CTI_J:    begin w_tgt_raw = w_pc4 + w_imm26; w_taken = 1'b1; end
            CTI_JAL:  begin w_tgt_raw = w_pc4 + w_imm26; w_taken = 1'b1; w_link = 1'b1; end
            CTI_BEQZ: begin w_tgt_raw = w_pc4 + w_imm16; w_taken = (bus.r_rs1 == '0); end
            CTI_BNEZ: begin w_tgt_raw = w_pc4 + w_imm16; w_taken = (bus.r_rs1 != '0); end
            CTI_JR:   begin w_tgt_raw = bus.r_rs1;       w_taken = 1'b1; end
            CTI_JALR: begin w_tgt_raw = bus.r_rs1;       w_taken = 1'b1; w_link = 1'b1; end
            default:  w_is_cti = 1'b0;
        endcase
    end

    assign w_tgt     = w_tgt_raw & ~XLEN'(3);
    assign w_mispred = (w_taken != bus.r_pred_taken) ||
                       (w_taken && bus.r_pred_taken && (w_tgt != bus.r_pred_target));

    always_ff @(posedge clk) begin
        if (rst || !bus.r_valid) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_link_we     <= 1'b0;
            r_link_data   <= '0;
        end else begin
            r_redirect    <= w_mispred;
            r_redirect_pc <= w_taken ? w_tgt : w_pc4;
            r_link_we     <= w_link;
            r_link_data   <= w_link ? w_pc4 : '0;
        end
    end

    assign bus.redirect    = r_redirect;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.link_we     = r_link_we;
    assign bus.link_data   = r_link_data;
    assign w_unused_fpc    = ^bus.f_pc;

`ifdef BRU_BTB_EN
    bru_btb #(
        .XLEN      (XLEN),
        .BTB_DEPTH (BTB_DEPTH),
        .CTR_BITS  (CTR_BITS)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .i_f_pc        (bus.f_pc[XLEN-1:2]),
        .o_pred_taken  (bus.f_pred_taken),
        .o_pred_target (bus.f_pred_target),
        .i_upd_en      (bus.r_valid),
        .i_upd_pc      (bus.r_pc[XLEN-1:2]),
        .i_upd_cti     (w_is_cti),
        .i_upd_taken   (w_taken),
        .i_upd_target  (w_tgt)
    );
`else
    // Static not-taken: fetch always falls through.
    assign bus.f_pred_taken  = 1'b0;
    assign bus.f_pred_target = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; prediction expectations
// follow whether BRU_BTB_EN is defined for the build.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

`ifdef BRU_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    branch_resolve_unit_if #(.XLEN(32)) bru_if ();

    branch_resolve_unit #(.XLEN(32), .BTB_DEPTH(16), .CTR_BITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bru_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] imm);
        return {op, imm};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd0, imm};
    endfunction

    task automatic start_resolve(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic pt, input logic [31:0] ptgt);
        @(negedge clk);
        bru_if.r_valid       = 1'b1;
        bru_if.r_instr       = instr;
        bru_if.r_pc          = pc;
        bru_if.r_rs1         = rs1;
        bru_if.r_pred_taken  = pt;
        bru_if.r_pred_target = ptgt;
    endtask

    task automatic end_resolve();
        @(negedge clk);
        bru_if.r_valid = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic pt, input logic [31:0] ptgt);
        start_resolve(instr, pc, rs1, pt, ptgt);
        end_resolve();
    endtask

    task automatic expect_out(input string tag, input logic rd, input logic [31:0] rpc,
                              input logic lwe, input logic [31:0] ld);
        check_val({tag, ".redirect"},    64'(bru_if.redirect),    64'(rd));
        check_val({tag, ".redirect_pc"}, 64'(bru_if.redirect_pc), 64'(rpc));
        check_val({tag, ".link_we"},     64'(bru_if.link_we),     64'(lwe));
        check_val({tag, ".link_data"},   64'(bru_if.link_data),   64'(ld));
    endtask

    task automatic expect_pred(input string tag, input logic [31:0] pc,
                               input logic taken, input logic [31:0] tgt);
        bru_if.f_pc = pc;
        #1;
        check_val({tag, ".f_pred_taken"},  64'(bru_if.f_pred_taken),  64'(taken & BTB_ON));
        check_val({tag, ".f_pred_target"}, 64'(bru_if.f_pred_target), BTB_ON ? 64'(tgt) : 64'h0);
    endtask

    initial begin
        logic [31:0] i_bnez;
        logic [31:0] i_add;
        i_bnez = mk_i(OP_BNEZ, 16'h0020);
        i_add  = 32'h0022_0820;
        bru_if.f_pc = '0;
        bru_if.r_valid = 1'b0;
        bru_if.r_instr = '0;
        bru_if.r_pc = '0;
        bru_if.r_rs1 = '0;
        bru_if.r_pred_taken = 1'b0;
        bru_if.r_pred_target = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        expect_pred("reset", 32'h100, 1'b0, 32'h0);

        // beqz taken, predicted not taken: redirect and BTB allocation
        resolve(mk_i(OP_BEQZ, 16'h0010), 32'h100, 32'h0, 1'b0, 32'h0);
        expect_out("beqz", 1'b1, 32'h114, 1'b0, 32'h0);
        expect_pred("beqz", 32'h100, 1'b1, 32'h114);
        @(negedge clk);
        expect_out("idle", 1'b0, 32'h0, 1'b0, 32'h0);

        resolve(mk_j(OP_JAL, 26'h3FFFFFC), 32'h200, 32'h0, 1'b1, 32'h200);
        expect_out("jal", 1'b0, 32'h200, 1'b1, 32'h204);

        resolve(mk_j(OP_JR, 26'h0), 32'h280, 32'h1237, 1'b1, 32'h1000);
        expect_out("jr", 1'b1, 32'h1234, 1'b0, 32'h0);

        resolve(mk_j(OP_JALR, 26'h0), 32'h2C0, 32'h5000, 1'b1, 32'h5000);
        expect_out("jalr", 1'b0, 32'h5000, 1'b1, 32'h2C4);

        resolve(mk_i(OP_BEQZ, 16'h0010), 32'h700, 32'h1, 1'b0, 32'h0);
        expect_out("beqz_nt", 1'b0, 32'h704, 1'b0, 32'h0);

        resolve(i_add, 32'h600, 32'h0, 1'b0, 32'h0);
        expect_out("add_nopred", 1'b0, 32'h604, 1'b0, 32'h0);

        // bnez taken at 0x344; the allocating cycle still sees the old (empty) entry
        bru_if.f_pc = 32'h344;
        start_resolve(i_bnez, 32'h344, 32'h5, 1'b0, 32'h0);
        #1;
        check_val("same_cycle.f_pred_taken", 64'(bru_if.f_pred_taken), 64'h0);
        end_resolve();
        expect_out("bnez_t", 1'b1, 32'h368, 1'b0, 32'h0);
        expect_pred("bnez_t", 32'h344, 1'b1, 32'h368);

        // three not-taken resolves: counter 2 -> 1 -> 0 -> 0
        for (int k = 0; k < 3; k++) begin
            resolve(i_bnez, 32'h344, 32'h0, (k == 0), 32'h368);
            expect_out($sformatf("bnez_nt%0d", k), (k == 0), 32'h348, 1'b0, 32'h0);
            expect_pred($sformatf("bnez_nt%0d", k), 32'h344, 1'b0, 32'h0);
        end
        // counter held at 0: first taken gives 1 (not predicted), second gives 2
        resolve(i_bnez, 32'h344, 32'h7, 1'b0, 32'h0);
        expect_out("bnez_t1", 1'b1, 32'h368, 1'b0, 32'h0);
        expect_pred("bnez_t1", 32'h344, 1'b0, 32'h0);
        resolve(i_bnez, 32'h344, 32'h7, 1'b0, 32'h0);
        expect_pred("bnez_t2", 32'h344, 1'b1, 32'h368);

        // non-CTI hitting a valid entry invalidates it
        resolve(i_add, 32'h344, 32'h0, 1'b1, 32'h368);
        expect_out("add_hit", 1'b1, 32'h348, 1'b0, 32'h0);
        expect_pred("add_hit", 32'h344, 1'b0, 32'h0);
        resolve(i_bnez, 32'h344, 32'h0, 1'b0, 32'h0);
        expect_out("post_inval_nt", 1'b0, 32'h348, 1'b0, 32'h0);
        resolve(i_bnez, 32'h344, 32'h9, 1'b0, 32'h0);
        expect_pred("post_inval_t", 32'h344, 1'b1, 32'h368);

        resolve(mk_j(OP_J, 26'h0000008), 32'h408, 32'h0, 1'b0, 32'h0);
        expect_out("j", 1'b1, 32'h414, 1'b0, 32'h0);
        expect_pred("j", 32'h408, 1'b1, 32'h414);

        // resolve in the reset cycle is dropped and the BTB is emptied
        @(negedge clk);
        rst = 1'b1;
        bru_if.r_valid = 1'b1;
        bru_if.r_instr = mk_j(OP_J, 26'h0000040);
        bru_if.r_pc = 32'h520;
        bru_if.r_pred_taken = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bru_if.r_valid = 1'b0;
        expect_out("rst_drop", 1'b0, 32'h0, 1'b0, 32'h0);
        expect_pred("rst_old", 32'h408, 1'b0, 32'h0);
        expect_pred("rst_new", 32'h520, 1'b0, 32'h0);
        expect_pred("rst_bnez", 32'h344, 1'b0, 32'h0);
        @(negedge clk);
        expect_out("post_rst", 1'b0, 32'h0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32: PC/register width, >= 32.
REQ-002 Parameter BTB_DEPTH, default 16: BTB entries, power of two, 2..256.
REQ-003 Parameter CTR_BITS, default 2: saturating-counter width, 1..4.
REQ-004 Ports SHALL be as follows; single clock clk, synchronous active-high reset rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 f_pc  in  XLEN  fetch PC for prediction lookup.
REQ-008 f_pred_taken  out  1  prediction for f_pc, combinational from registered table.
REQ-009 f_pred_target  out  XLEN  predicted target, 0 when not predicted taken.
REQ-010 r_valid  in  1  resolve request this cycle.
REQ-011 r_instr  in  32  DLX instruction being resolved.
REQ-012 r_pc  in  XLEN  PC of r_instr.
REQ-013 r_rs1  in  XLEN  forwarded value of register rs.
REQ-014 r_pred_taken / r_pred_target  in  1 / XLEN  prediction carried down the pipe.
REQ-015 redirect  out  1  one-cycle pulse, fetch flushes and restarts at redirect_pc.
REQ-016 redirect_pc  out  XLEN  corrected fetch PC.
REQ-017 link_we / link_data  out  1 / XLEN  write of r31 for jal/jalr.

Function
REQ-018 Decode SHALL cover opcode 0x02 j, 0x03 jal, 0x04 beqz, 0x05 bnez, 0x12 jr, 0x13 jalr; all others are non-CTI.
REQ-019 j/jal target SHALL be r_pc+4+sign-extended instr[25:0]; beqz/bnez target r_pc+4+sign-extended instr[15:0]; jr/jalr target r_rs1; all sums modulo 2^XLEN; target bits[1:0] forced to 0.
REQ-020 Actual taken: j/jal/jr/jalr always; beqz iff r_rs1==0; bnez iff r_rs1!=0; non-CTI never.
REQ-021 Outputs redirect, redirect_pc, link_we, link_data SHALL be registered, valid exactly one cycle after the r_valid cycle; zero when r_valid was low.
REQ-022 redirect SHALL assert iff actual taken != r_pred_taken, or both taken and target != r_pred_target.
REQ-023 redirect_pc SHALL be actual target if taken, else r_pc+4.
REQ-024 link_we SHALL assert for jal/jalr with link_data = r_pc+4, independent of redirect.
REQ-025 BTB entry: valid, tag = r_pc[XLEN-1:idx+2], index = r_pc[log2(BTB_DEPTH)+1:2], target, counter.
REQ-026 Prediction: f_pred_taken = hit and counter MSB set.
REQ-027 BTB update on r_valid cycle, visible next cycle; same-cycle lookup of updated index returns old contents.
REQ-028 CTI hit: counter +1 if taken, -1 if not, saturating at max and 0; target rewritten when taken.
REQ-029 CTI miss and taken: allocate/overwrite entry, counter = weakly taken (MSB set, rest 0). Miss and not taken: no write.
REQ-030 Non-CTI that hits SHALL invalidate the entry.

Reset
REQ-031 rst SHALL clear all BTB valid bits and all registered outputs to 0 in one cycle.
REQ-032 A resolve presented in the rst cycle SHALL be dropped: no update, no redirect next cycle.

Configuration
REQ-033 Macro BRU_BTB_EN: defined -> BTB as above; undefined -> no table storage, f_pred_taken=0, f_pred_target=0, REQ-025..030 void, resolve/redirect unchanged (static not-taken).

Structure
REQ-034 Shared package SHALL hold the DLX opcode constants, a cti_kind enum (NONE, J, JAL, BEQZ, BNEZ, JR, JALR) and the BTB-entry struct.
REQ-035 One sub-module, bru_btb, SHALL hold table storage, lookup and update; decode/target/compare remain in the top.

Verification
REQ-036 After rst, r_valid with beqz at r_pc=0x100, imm=0x0010, r_rs1=0, r_pred_taken=0 -> next cycle redirect=1, redirect_pc=0x114; later f_pc=0x100 -> f_pred_taken=1, f_pred_target=0x114.
REQ-037 jal r_pc=0x200, instr[25:0]=0x3FFFFFC (-4), r_pred_taken=1, r_pred_target=0x200 -> redirect=0, link_we=1, link_data=0x204.
REQ-038 jr r_rs1=0x0000_1237, predicted 0x1000 -> redirect=1, redirect_pc=0x1234.
REQ-039 bnez same PC resolved not taken 3 times from weakly taken (CTR_BITS=2) -> f_pred_taken 0 after first, counter holds 0, no underflow.
REQ-040 Resolve add at a PC with valid entry and r_pred_taken=1 -> redirect_pc=r_pc+4, entry invalidated; rst asserted with r_valid -> no redirect, BTB empty.
